uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Parametrised UART program loader: receives serial frames on `RX` while `Load` is high and writes each error-free word into program memory at an auto-incrementing address. It sits between the external serial line and the CPU instruction memory write port, and holds the CPU in load mode until the image is complete. It generalises the fixed 8N1, 32-word loader with:
- configurable word width, depth, parity and stop bits;
- parity and framing error detection;
- a completion flag.

## Interface
Parameters:
- `BAUD_DIV`, 24: clock cycles per bit; legal range 4..65535.
- `DATA_W`, 8: data bits per frame, sent LSB first; legal range 5..9.
- `ADDR_W`, 5: memory address width; depth = 2^ADDR_W.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `Clk` in 1: single clock. All logic on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `Load` in 1: load enable, level-sensitive.
- `RX` in 1: serial input, idle high, asynchronous to `Clk`.
- `Wr_en` out 1: one-cycle memory write strobe.
- `Wr_addr` out ADDR_W: write address.
- `Wr_data` out DATA_W: write data.
- `Busy` out 1: high while a frame is being received.
- `Done` out 1: high once 2^ADDR_W words have been written in the current load session.
- `FE` out 1: sticky framing error.
- `PE` out 1: sticky parity error.
- `Word_count` out ADDR_W+1: words written in the current session.

## Operation
- **Input sync:** `RX` passes through a 2-FF synchroniser, `rx_s`. All decisions use `rx_s`.
- **Baud counter:** counts 0..BAUD_DIV-1.
- **States:** IDLE, START, DATA, PAR, STOP, WRITE.
  - IDLE: on `Load`=1 and `rx_s`=0, go to START and clear the baud counter.
  - START: at count BAUD_DIV/2-1 (mid start bit), sample `rx_s`.
    - 0: go to DATA.
    - 1: false start; return to IDLE, no error.
  - DATA: sample every BAUD_DIV cycles into a shift register, LSB first. After DATA_W samples, go to PAR if PARITY≠0, else STOP.
  - PAR: sample one bit and compare with computed parity. A mismatch sets an internal frame-bad flag and `PE`.
  - STOP: sample STOP_BITS bits. Any 0 sets frame-bad and `FE`. After the last stop sample, go to WRITE if the frame is good, else IDLE.
  - WRITE: one cycle. Assert `Wr_en` with `Wr_data` = shift register and `Wr_addr` = address counter. Increment address and `Word_count`, then go to IDLE.
- **Address wrap:** when the address counter reaches 2^ADDR_W-1 and is written:
  - the address wraps to 0;
  - `Word_count` reaches 2^ADDR_W and sets `Done`;
  - further frames are still received but not written; `Wr_en` stays low, address and count stay frozen.
- **Bad frames:** no write, no address increment.
- **Load rising edge:** clears `FE`, `PE`, `Done`, `Word_count` and the address counter to 0.
- **Load falling:**
  - from any non-IDLE state: abort in the next cycle and go to IDLE; the partial frame is discarded and `Wr_en` is not asserted.
  - with `Load`=0: `Done`, `FE`, `PE` and `Word_count` hold their values.
- **Busy:** 1 in START, DATA, PAR and STOP; 0 in IDLE and WRITE.

## Timing
- **Reset values:** all outputs 0, state IDLE, address counter 0, synchroniser flops 1. Reset mid-frame returns to IDLE at the next edge with no write.
- **Synchroniser latency:** 2 cycles from an `RX` edge to `rx_s`.
- **Sample points:** first data bit sampled BAUD_DIV/2 + BAUD_DIV cycles after `rx_s` falls; each subsequent bit BAUD_DIV cycles later.
- **Write latency:** `Wr_en` rises the cycle after the final stop-bit sample and lasts exactly 1 cycle.
- **Data validity:** `Wr_addr` and `Wr_data` are valid only while `Wr_en`=1.
- **Flag timing:** `Done` rises in the same cycle as the final `Wr_en` and stays high until the next `Load` rising edge or `Reset`.
- **Back-to-back frames:** a start bit immediately following the stop bit is accepted. The WRITE cycle lies inside the stop bit's second half, so no frame is lost at BAUD_DIV≥4.
- **Simultaneous events:**
  - `Load` falling in the WRITE cycle: the write completes.
  - `Load` rising together with a start edge: clear first, then receive.

## Test plan
Defaults unless stated; `Clk` period 4 ns, so 1 bit = 96 ns.
- **Full load:** send 32 bytes 0x00..0x1F. Expect 32 `Wr_en` pulses with `Wr_addr`=`Wr_data`=n, `Done`=1 after byte 31, `Word_count`=32, `FE`=0.
- **Framing error:** send 0xFE with stop bit forced 0, then 0xA5 normally. Expect `FE`=1, no write for 0xFE, and 0xA5 written at address 0.
- **Even parity:** PARITY=1. Send 0x03 with parity bit 0, then 0x03 with parity bit 1. Expect a write of 0x03 at address 0, then `PE`=1 and no second write.
- **Abort and glitch:** drop `Load` after 4 data bits of 0xE3; expect no write and `Busy`=0 two cycles later. Separately, a 20 ns `RX` low glitch is a false start: no write, no error.
- **Overflow:** ADDR_W=2, send 6 bytes. Expect writes at addresses 0..3 only, `Done`=1, `Word_count`=4.
- **Reset and 9-bit mode:** assert `Reset` mid-frame; expect all outputs 0 next cycle and that frame discarded. Then DATA_W=9, STOP_BITS=2, send 0x1A5; expect `Wr_data`=0x1A5.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART program loader: deserialises frames on i_RX while i_Load is high and
// writes each good word to program memory at an auto-incrementing address.
module uart_prog_loader #(
  parameter int BAUD_DIV  = 24,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Load,
  input  logic              i_RX,
  output logic              o_Wr_en,
  output logic [ADDR_W-1:0] o_Wr_addr,
  output logic [DATA_W-1:0] o_Wr_data,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_FE,
  output logic              o_PE,
  output logic [ADDR_W:0]   o_Word_count
);

  localparam logic [15:0]   BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0]   HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WRITE
  } state_t;

  state_t              r_state, w_next;
  logic                r_sync1, r_sync2, r_loadD;
  logic [15:0]         r_baud;
  logic [3:0]          r_bitCnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_bad, r_fe, r_pe;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;

  logic w_rx, w_loadRise, w_bitTick, w_midStart, w_full, w_parExp;

  assign w_rx       = r_sync2;
  assign w_loadRise = i_Load & ~r_loadD;
  assign w_bitTick  = (r_baud == BIT_LAST);
  assign w_midStart = (r_baud == HALF_LAST);
  assign w_full     = r_count[ADDR_W];
  assign w_parExp   = (PARITY == 2) ? ~(^r_shift) : ^r_shift;

  // Dropping Load aborts any frame in flight, but a WRITE already under way completes
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_Load && !w_rx) w_next = S_START;
      S_START: if (w_midStart) w_next = w_rx ? S_IDLE : S_DATA;
      S_DATA:  if (w_bitTick && r_bitCnt == DATA_LAST)
                 w_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_bitTick) w_next = S_STOP;
      S_STOP:  if (w_bitTick && r_bitCnt == STOP_LAST)
                 w_next = (!r_bad && w_rx && !w_full) ? S_WRITE : S_IDLE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (!i_Load && r_state != S_WRITE) w_next = S_IDLE;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_loadD  <= 1'b0;
      r_baud   <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_bad    <= 1'b0;
      r_fe     <= 1'b0;
      r_pe     <= 1'b0;
      r_addr   <= '0;
      r_count  <= '0;
    end else begin
      r_sync1 <= i_RX;
      r_sync2 <= r_sync1;
      r_loadD <= i_Load;
      r_state <= w_next;

      // Baud and bit counters restart on every state change
      if (w_next != r_state || r_state == S_IDLE || w_bitTick) r_baud <= '0;
      else r_baud <= r_baud + 16'd1;

      if (w_next != r_state) r_bitCnt <= '0;
      else if (w_bitTick)    r_bitCnt <= r_bitCnt + 4'd1;

      if (r_state == S_IDLE) r_bad <= 1'b0;
      if (r_state == S_DATA && w_bitTick) r_shift <= {w_rx, r_shift[DATA_W-1:1]};
      if (r_state == S_PAR && w_bitTick && w_rx != w_parExp) begin
        r_bad <= 1'b1;
        r_pe  <= 1'b1;
      end
      if (r_state == S_STOP && w_bitTick && !w_rx) begin
        r_bad <= 1'b1;
        r_fe  <= 1'b1;
      end

      // A new load session clears the sticky flags and the write pointer
      if (w_loadRise) begin
        r_fe    <= 1'b0;
        r_pe    <= 1'b0;
        r_addr  <= '0;
        r_count <= '0;
      end else if (r_state == S_WRITE) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_Wr_en      = (r_state == S_WRITE);
  assign o_Wr_addr    = r_addr;
  assign o_Wr_data    = r_shift;
  assign o_Busy       = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PAR)   || (r_state == S_STOP);
  assign o_Done       = w_full || (o_Wr_en && r_count == LAST_CNT);
  assign o_FE         = r_fe;
  assign o_PE         = r_pe;
  assign o_Word_count = r_count;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: three instances cover the default
// 8N1 loader, even parity with a 4-word memory, and 9-bit data with 2 stop bits.
module tb_uart_prog_loader;

  localparam int BAUD = 24;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst0, rst12;
  logic load0, load1, load2;
  logic rx0, rx1, rx2;

  logic       wrEn0, busy0, done0, fe0, pe0;
  logic [4:0] wrAddr0;
  logic [7:0] wrData0;
  logic [5:0] wc0;

  logic       wrEn1, busy1, done1, fe1, pe1;
  logic [1:0] wrAddr1;
  logic [7:0] wrData1;
  logic [2:0] wc1;

  logic       wrEn2, busy2, done2, fe2, pe2;
  logic [4:0] wrAddr2;
  logic [8:0] wrData2;
  logic [5:0] wc2;

  wr_t q0[$], q1[$], q2[$];
  wr_t e0, e1, e2;
  int  checks = 0;
  int  errors = 0;

  always #2 clk = ~clk;

  uart_prog_loader u0 (
    .i_Clk(clk), .i_Reset(rst0), .i_Load(load0), .i_RX(rx0),
    .o_Wr_en(wrEn0), .o_Wr_addr(wrAddr0), .o_Wr_data(wrData0), .o_Busy(busy0),
    .o_Done(done0), .o_FE(fe0), .o_PE(pe0), .o_Word_count(wc0)
  );

  uart_prog_loader #(.PARITY(1), .ADDR_W(2)) u1 (
    .i_Clk(clk), .i_Reset(rst12), .i_Load(load1), .i_RX(rx1),
    .o_Wr_en(wrEn1), .o_Wr_addr(wrAddr1), .o_Wr_data(wrData1), .o_Busy(busy1),
    .o_Done(done1), .o_FE(fe1), .o_PE(pe1), .o_Word_count(wc1)
  );

  uart_prog_loader #(.DATA_W(9), .STOP_BITS(2)) u2 (
    .i_Clk(clk), .i_Reset(rst12), .i_Load(load2), .i_RX(rx2),
    .o_Wr_en(wrEn2), .o_Wr_addr(wrAddr2), .o_Wr_data(wrData2), .o_Busy(busy2),
    .o_Done(done2), .o_FE(fe2), .o_PE(pe2), .o_Word_count(wc2)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic setRx(input int idx, input logic v);
    case (idx)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic bitWait();
    repeat (BAUD) @(negedge clk);
  endtask

  // One full frame; parBit < 0 means no parity bit is sent
  task automatic applyStimulus(input int idx, input int data, input int nData,
                               input int parBit, input int nStop, input logic stopVal);
    setRx(idx, 1'b0);
    bitWait();
    for (int i = 0; i < nData; i++) begin
      setRx(idx, data[i]);
      bitWait();
    end
    if (parBit >= 0) begin
      setRx(idx, parBit[0]);
      bitWait();
    end
    for (int i = 0; i < nStop; i++) begin
      setRx(idx, stopVal);
      bitWait();
    end
    setRx(idx, 1'b1);
  endtask

  // Scoreboard monitors: every Wr_en pulse must match the oldest expected write
  always @(negedge clk) begin
    if (wrEn0) begin
      if (q0.size() == 0) checkOutput("u0 unexpected Wr_en", 1, 0);
      else begin
        e0 = q0.pop_front();
        checkOutput("u0 Wr_addr", int'(wrAddr0), e0.addr);
        checkOutput("u0 Wr_data", int'(wrData0), e0.data);
        checkOutput("u0 Done with Wr_en", int'(done0), int'(e0.addr == 31));
      end
    end
    if (wrEn1) begin
      if (q1.size() == 0) checkOutput("u1 unexpected Wr_en", 1, 0);
      else begin
        e1 = q1.pop_front();
        checkOutput("u1 Wr_addr", int'(wrAddr1), e1.addr);
        checkOutput("u1 Wr_data", int'(wrData1), e1.data);
        checkOutput("u1 Done with Wr_en", int'(done1), int'(e1.addr == 3));
      end
    end
    if (wrEn2) begin
      if (q2.size() == 0) checkOutput("u2 unexpected Wr_en", 1, 0);
      else begin
        e2 = q2.pop_front();
        checkOutput("u2 Wr_addr", int'(wrAddr2), e2.addr);
        checkOutput("u2 Wr_data", int'(wrData2), e2.data);
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst12 = 1'b1;
    load0 = 1'b0; load1 = 1'b0; load2 = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset Wr_en", int'(wrEn0), 0);
    checkOutput("reset Busy", int'(busy0), 0);
    checkOutput("reset Done", int'(done0), 0);
    checkOutput("reset FE/PE", int'({fe0, pe0}), 0);
    checkOutput("reset Word_count", int'(wc0), 0);
    checkOutput("reset Wr_data u2", int'(wrData2), 0);
    rst0 = 1'b0; rst12 = 1'b0;
    repeat (2) @(negedge clk);

    // Full load of 32 back-to-back frames
    load0 = 1'b1;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 32; n++) begin
      q0.push_back('{addr: n, data: n});
      applyStimulus(0, n, 8, -1, 1, 1'b1);
    end
    repeat (5) @(negedge clk);
    checkOutput("full Done", int'(done0), 1);
    checkOutput("full Word_count", int'(wc0), 32);
    checkOutput("full FE", int'(fe0), 0);
    checkOutput("full queue drained", q0.size(), 0);

    // Framing error then a good frame in a fresh session
    load0 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("Load low holds count", int'(wc0), 32);
    load0 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("Load rise clears Done", int'(done0), 0);
    checkOutput("Load rise clears count", int'(wc0), 0);
    applyStimulus(0, 'hFE, 8, -1, 1, 1'b0);
    repeat (3 * BAUD) @(negedge clk);
    checkOutput("FE set", int'(fe0), 1);
    q0.push_back('{addr: 0, data: 'hA5});
    applyStimulus(0, 'hA5, 8, -1, 1, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("FE sticky", int'(fe0), 1);
    checkOutput("FE count", int'(wc0), 1);

    // Abort after 4 data bits of 0xE3
    rx0 = 1'b0;
    bitWait();
    for (int i = 0; i < 4; i++) begin
      rx0 = (i < 2) ? 1'b1 : 1'b0;
      bitWait();
    end
    checkOutput("Busy mid-frame", int'(busy0), 1);
    load0 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort Busy", int'(busy0), 0);
    rx0 = 1'b1;
    repeat (6 * BAUD) @(negedge clk);
    checkOutput("abort count", int'(wc0), 1);

    // 20 ns glitch is a false start
    load0 = 1'b1;
    repeat (2) @(negedge clk);
    rx0 = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    checkOutput("glitch Busy", int'(busy0), 0);
    checkOutput("glitch FE", int'(fe0), 0);
    checkOutput("glitch count", int'(wc0), 0);

    // Reset in the middle of a frame
    q0.push_back('{addr: 0, data: 'h3C});
    applyStimulus(0, 'h3C, 8, -1, 1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("pre-reset count", int'(wc0), 1);
    rx0 = 1'b0;
    bitWait();
    for (int i = 0; i < 3; i++) begin
      rx0 = i[0] ? 1'b0 : 1'b1;
      bitWait();
    end
    rst0 = 1'b1;
    @(negedge clk);
    checkOutput("mid reset Busy", int'(busy0), 0);
    checkOutput("mid reset Wr_en", int'(wrEn0), 0);
    checkOutput("mid reset count", int'(wc0), 0);
    checkOutput("mid reset Wr_data", int'(wrData0), 0);
    rst0 = 1'b0;
    rx0 = 1'b1;
    repeat (8 * BAUD) @(negedge clk);
    checkOutput("post reset count", int'(wc0), 0);

    // Even parity: good 0x03 (parity 0), then bad 0x03 (parity 1)
    load1 = 1'b1;
    repeat (2) @(negedge clk);
    q1.push_back('{addr: 0, data: 'h03});
    applyStimulus(1, 'h03, 8, 0, 1, 1'b1);
    applyStimulus(1, 'h03, 8, 1, 1, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("parity PE", int'(pe1), 1);
    checkOutput("parity count", int'(wc1), 1);
    checkOutput("parity FE", int'(fe1), 0);

    // Overflow: 6 frames into a 4-word memory
    load1 = 1'b0;
    repeat (3) @(negedge clk);
    load1 = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      d = 8'(8'h10 + k);
      if (k < 4) q1.push_back('{addr: k, data: int'(d)});
      applyStimulus(1, int'(d), 8, int'(^d), 1, 1'b1);
    end
    repeat (5) @(negedge clk);
    checkOutput("overflow Done", int'(done1), 1);
    checkOutput("overflow count", int'(wc1), 4);
    checkOutput("overflow PE", int'(pe1), 0);

    // 9-bit data, 2 stop bits, back-to-back
    load2 = 1'b1;
    repeat (2) @(negedge clk);
    q2.push_back('{addr: 0, data: 'h1A5});
    applyStimulus(2, 'h1A5, 9, -1, 2, 1'b1);
    q2.push_back('{addr: 1, data: 'h0F3});
    applyStimulus(2, 'h0F3, 9, -1, 2, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("9-bit count", int'(wc2), 2);
    checkOutput("9-bit FE", int'(fe2), 0);

    checkOutput("q0 drained", q0.size(), 0);
    checkOutput("q1 drained", q1.size(), 0);
    checkOutput("q2 drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
